// File: rtl/mem_bus_ctrl.sv
// Memory bus controller: ROM/RAM/IO decode, per-region wait states, external strobes, IO page.
// Optional cycle timer and snapshot register are built only when MEM_BUS_TIMER_EN is defined.
module mem_bus_ctrl #(
    parameter int unsigned ADR_TOP = 15,
    parameter int unsigned ROM_WS  = 1,
    parameter int unsigned RAM_WS  = 1,
    parameter int unsigned IO_WS   = 0,
    parameter logic [7:0]  IO_PAGE = 8'hFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             m_req,
    input  logic             m_wr,
    input  logic [ADR_TOP:0] m_addr,
    input  logic [7:0]       m_outdata,
    output logic [7:0]       m_indata,
    output logic             m_wait,
    output logic [ADR_TOP:0] ext_addr,
    output logic [7:0]       ext_wdata,
    input  logic [7:0]       ext_rdata,
    output logic             rom_ce_n,
    output logic             ram_ce_n,
    output logic             ext_oe_n,
    output logic             ext_we_n,
    input  logic [7:0]       gpio_in,
    output logic [7:0]       gpio_out
);

    localparam int unsigned CW        = 4;
    localparam int unsigned RAM_WR_WS = (RAM_WS < 1) ? 1 : RAM_WS;

    logic          is_io;
    logic          is_rom;
    logic          is_ram;
    logic [CW-1:0] ws;
    logic [CW-1:0] cnt;
    logic          done;
    logic          io_wr;
    logic [1:0]    reg_sel;
    logic [7:0]    gpio_meta;
    logic [7:0]    gpio_sync;
    logic [7:0]    timer_lo;
    logic [7:0]    snap_val;
    logic [7:0]    io_rdata;

    // Region decode; the IO page overrides the RAM half.
    assign is_io  = (m_addr[ADR_TOP -: 8] == IO_PAGE);
    assign is_rom = ~is_io & ~m_addr[ADR_TOP];
    assign is_ram = ~is_io &  m_addr[ADR_TOP];

    always_comb begin
        ws = CW'(IO_WS);
        if (is_rom)
            ws = CW'(ROM_WS);
        else if (is_ram)
            ws = m_wr ? CW'(RAM_WR_WS) : CW'(RAM_WS);
    end

    assign m_wait  = m_req & (cnt != ws);
    assign done    = m_req & ~m_wait;
    assign io_wr   = done & m_wr & is_io;
    assign reg_sel = m_addr[1:0];

    assign ext_addr  = m_addr;
    assign ext_wdata = m_outdata;
    assign rom_ce_n  = ~(m_req & is_rom);
    assign ram_ce_n  = ~(m_req & is_ram);
    assign ext_oe_n  = ~(m_req & ~m_wr & ~is_io);
    assign ext_we_n  = ~(m_req & m_wr & is_ram & ~m_wait);

    // Counter clears on every completion so back-to-back accesses restart at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (!m_req || done)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gpio_out  <= '0;
            gpio_meta <= '0;
            gpio_sync <= '0;
        end else begin
            gpio_meta <= gpio_in;
            gpio_sync <= gpio_meta;
            if (io_wr && reg_sel == 2'd0)
                gpio_out <= m_outdata;
        end
    end

`ifdef MEM_BUS_TIMER_EN
    logic        io_rd;
    logic [15:0] timer;
    logic [7:0]  snap;

    assign io_rd = done & ~m_wr & is_io;

    // Reading the low byte captures the high byte from the same pre-increment value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer <= '0;
            snap  <= '0;
        end else begin
            if (io_wr && reg_sel == 2'd2)
                timer <= '0;
            else
                timer <= timer + 16'd1;
            if (io_rd && reg_sel == 2'd2)
                snap <= timer[15:8];
        end
    end

    assign timer_lo = timer[7:0];
    assign snap_val = snap;
`else
    assign timer_lo = 8'h00;
    assign snap_val = 8'h00;
`endif

    always_comb begin
        io_rdata = 8'h00;
        case (reg_sel)
            2'd0: io_rdata = gpio_out;
            2'd1: io_rdata = gpio_sync;
            2'd2: io_rdata = timer_lo;
            2'd3: io_rdata = snap_val;
            default: io_rdata = 8'h00;
        endcase
    end

    always_comb begin
        m_indata = 8'h00;
        if (m_req && !m_wr)
            m_indata = is_io ? io_rdata : ext_rdata;
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed self-checking bench for mem_bus_ctrl with default parameters.
module tb_mem_bus_ctrl;

    logic        clk;
    logic        rst;
    logic        m_req;
    logic        m_wr;
    logic [15:0] m_addr;
    logic [7:0]  m_outdata;
    logic [7:0]  m_indata;
    logic        m_wait;
    logic [15:0] ext_addr;
    logic [7:0]  ext_wdata;
    logic [7:0]  ext_rdata;
    logic        rom_ce_n;
    logic        ram_ce_n;
    logic        ext_oe_n;
    logic        ext_we_n;
    logic [7:0]  gpio_in;
    logic [7:0]  gpio_out;

    int checks = 0;
    int errors = 0;

    mem_bus_ctrl dut (
        .clk(clk), .rst(rst), .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr),
        .m_outdata(m_outdata), .m_indata(m_indata), .m_wait(m_wait),
        .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_rdata(ext_rdata),
        .rom_ce_n(rom_ce_n), .ram_ce_n(ram_ce_n), .ext_oe_n(ext_oe_n),
        .ext_we_n(ext_we_n), .gpio_in(gpio_in), .gpio_out(gpio_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; m_req = 1'b0; m_wr = 1'b0; m_addr = 16'h0000;
        m_outdata = 8'h00; ext_rdata = 8'h00; gpio_in = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (m_wait !== 1'b0) begin errors++; $display("FAIL reset_wait got %b exp 0", m_wait); end
        checks++; if ({rom_ce_n, ram_ce_n, ext_oe_n, ext_we_n} !== 4'b1111) begin errors++;
            $display("FAIL reset_strobes got %b exp 1111", {rom_ce_n, ram_ce_n, ext_oe_n, ext_we_n}); end
        checks++; if (gpio_out !== 8'h00) begin errors++; $display("FAIL reset_gpio got %h exp 00", gpio_out); end
        checks++; if (m_indata !== 8'h00) begin errors++; $display("FAIL reset_indata got %h exp 00", m_indata); end
        rst = 1'b1;
        next_cycle();
    endtask

    task automatic test_rom_read();
        m_req = 1'b1; m_wr = 1'b0; m_addr = 16'h0010; ext_rdata = 8'hA5;
        @(negedge clk);
        checks++; if (m_wait !== 1'b1) begin errors++; $display("FAIL rom_rd_wait1 got %b exp 1", m_wait); end
        checks++; if ({rom_ce_n, ram_ce_n, ext_oe_n, ext_we_n} !== 4'b0101) begin errors++;
            $display("FAIL rom_rd_strb1 got %b exp 0101", {rom_ce_n, ram_ce_n, ext_oe_n, ext_we_n}); end
        next_cycle();
        @(negedge clk);
        checks++; if (m_wait !== 1'b0) begin errors++; $display("FAIL rom_rd_wait2 got %b exp 0", m_wait); end
        checks++; if (m_indata !== 8'hA5) begin errors++; $display("FAIL rom_rd_data got %h exp a5", m_indata); end
        checks++; if ({rom_ce_n, ext_oe_n} !== 2'b00) begin errors++;
            $display("FAIL rom_rd_strb2 got %b exp 00", {rom_ce_n, ext_oe_n}); end
        next_cycle();
        m_req = 1'b0;
        next_cycle();
    endtask

    task automatic test_ram_write();
        m_req = 1'b1; m_wr = 1'b1; m_addr = 16'h8001; m_outdata = 8'h3C;
        @(negedge clk);
        checks++; if (m_wait !== 1'b1) begin errors++; $display("FAIL ram_wr_wait1 got %b exp 1", m_wait); end
        checks++; if ({rom_ce_n, ram_ce_n, ext_oe_n, ext_we_n} !== 4'b1011) begin errors++;
            $display("FAIL ram_wr_strb1 got %b exp 1011", {rom_ce_n, ram_ce_n, ext_oe_n, ext_we_n}); end
        next_cycle();
        @(negedge clk);
        checks++; if (m_wait !== 1'b0) begin errors++; $display("FAIL ram_wr_wait2 got %b exp 0", m_wait); end
        checks++; if ({rom_ce_n, ram_ce_n, ext_oe_n, ext_we_n} !== 4'b1010) begin errors++;
            $display("FAIL ram_wr_strb2 got %b exp 1010", {rom_ce_n, ram_ce_n, ext_oe_n, ext_we_n}); end
        checks++; if ({ext_addr, ext_wdata} !== {16'h8001, 8'h3C}) begin errors++;
            $display("FAIL ram_wr_bus got %h %h exp 8001 3c", ext_addr, ext_wdata); end
        next_cycle();
        m_req = 1'b0;
        next_cycle();
    endtask

    task automatic test_rom_write();
        m_req = 1'b1; m_wr = 1'b1; m_addr = 16'h0005; m_outdata = 8'hEE;
        @(negedge clk);
        checks++; if ({m_wait, ext_oe_n, ext_we_n} !== 3'b111) begin errors++;
            $display("FAIL rom_wr_c1 got %b exp 111", {m_wait, ext_oe_n, ext_we_n}); end
        next_cycle();
        @(negedge clk);
        checks++; if ({m_wait, ext_oe_n, ext_we_n} !== 3'b011) begin errors++;
            $display("FAIL rom_wr_c2 got %b exp 011", {m_wait, ext_oe_n, ext_we_n}); end
        next_cycle();
        m_req = 1'b0;
        next_cycle();
    endtask

    task automatic test_back_to_back();
        m_req = 1'b1; m_wr = 1'b0; m_addr = 16'h0000; ext_rdata = 8'h11;
        @(negedge clk);
        checks++; if (m_wait !== 1'b1) begin errors++; $display("FAIL b2b_a_wait1 got %b exp 1", m_wait); end
        next_cycle();
        @(negedge clk);
        checks++; if ({m_wait, m_indata} !== {1'b0, 8'h11}) begin errors++;
            $display("FAIL b2b_a_done got %b %h exp 0 11", m_wait, m_indata); end
        next_cycle();
        m_addr = 16'h0001; ext_rdata = 8'h22;
        @(negedge clk);
        checks++; if (m_wait !== 1'b1) begin errors++; $display("FAIL b2b_b_wait1 got %b exp 1", m_wait); end
        next_cycle();
        @(negedge clk);
        checks++; if ({m_wait, m_indata} !== {1'b0, 8'h22}) begin errors++;
            $display("FAIL b2b_b_done got %b %h exp 0 22", m_wait, m_indata); end
        next_cycle();
        m_req = 1'b0;
        next_cycle();
    endtask

    task automatic test_gpio();
        m_req = 1'b1; m_wr = 1'b1; m_addr = 16'hFF00; m_outdata = 8'h5A;
        @(negedge clk);
        checks++; if ({m_wait, rom_ce_n, ram_ce_n, ext_oe_n, ext_we_n} !== 5'b01111) begin errors++;
            $display("FAIL gpio_wr_c1 got %b exp 01111", {m_wait, rom_ce_n, ram_ce_n, ext_oe_n, ext_we_n}); end
        next_cycle();
        m_wr = 1'b0; m_addr = 16'hFF04; ext_rdata = 8'hC3;
        @(negedge clk);
        checks++; if (gpio_out !== 8'h5A) begin errors++; $display("FAIL gpio_out got %h exp 5a", gpio_out); end
        checks++; if ({m_wait, m_indata} !== {1'b0, 8'h5A}) begin errors++;
            $display("FAIL gpio_alias_rd got %b %h exp 0 5a", m_wait, m_indata); end
        next_cycle();
        m_addr = 16'hFF01; gpio_in = 8'h81;
        next_cycle();
        @(negedge clk);
        checks++; if (m_indata !== 8'h00) begin errors++; $display("FAIL gpio_in_1clk got %h exp 00", m_indata); end
        next_cycle();
        @(negedge clk);
        checks++; if (m_indata !== 8'h81) begin errors++; $display("FAIL gpio_in_2clk got %h exp 81", m_indata); end
        next_cycle();
        m_req = 1'b0;
        next_cycle();
    endtask

    task automatic test_timer();
        logic [7:0] exp_lo;
        logic [7:0] exp_hi;
`ifdef MEM_BUS_TIMER_EN
        exp_lo = 8'h34; exp_hi = 8'h12;
`else
        exp_lo = 8'h00; exp_hi = 8'h00;
`endif
        m_req = 1'b1; m_wr = 1'b1; m_addr = 16'hFF02; m_outdata = 8'h00;
        @(posedge clk);
        #1;
        m_req = 1'b0; m_wr = 1'b0;
        repeat (16'h1234) @(posedge clk);
        #1;
        m_req = 1'b1; m_addr = 16'hFF02;
        @(negedge clk);
        checks++; if ({m_wait, m_indata} !== {1'b0, exp_lo}) begin errors++;
            $display("FAIL timer_lo got %b %h exp 0 %h", m_wait, m_indata, exp_lo); end
        next_cycle();
        m_addr = 16'hFF03;
        @(negedge clk);
        checks++; if (m_indata !== exp_hi) begin errors++; $display("FAIL timer_snap got %h exp %h", m_indata, exp_hi); end
        next_cycle();
        m_req = 1'b0;
        next_cycle();
    endtask

    task automatic test_async_reset();
        m_req = 1'b1; m_wr = 1'b0; m_addr = 16'h8002; ext_rdata = 8'h77;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        checks++; if ({m_wait, gpio_out} !== {1'b0, 8'h5A}) begin errors++;
            $display("FAIL arst_pre got %b %h exp 0 5a", m_wait, gpio_out); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (m_wait !== 1'b1) begin errors++; $display("FAIL arst_cnt_clear got %b exp 1", m_wait); end
        checks++; if (gpio_out !== 8'h00) begin errors++; $display("FAIL arst_gpio got %h exp 00", gpio_out); end
        m_req = 1'b0;
        #1;
        checks++; if ({m_wait, rom_ce_n, ram_ce_n, ext_oe_n, ext_we_n} !== 5'b01111) begin errors++;
            $display("FAIL arst_idle got %b exp 01111", {m_wait, rom_ce_n, ram_ce_n, ext_oe_n, ext_we_n}); end
        next_cycle();
        rst = 1'b1;
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_rom_read();
        test_ram_write();
        test_rom_write();
        test_back_to_back();
        test_gpio();
        test_timer();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
